// File: rtl/ram_with_ecc_pkg.sv
// rtl/ram_with_ecc_pkg.sv - SECDED geometry and codeword position helpers
// Purpose: compile-time helpers shared by the codec, the RAM top and the bench.
//   ecc_parity_bits(dw) : number of Hamming check bits P (2**P >= dw+P+1)
//   ecc_code_width(dw)  : full codeword width, dw + P + 1 (bit 0 = overall parity)
//   ecc_is_check_pos(p) : position p holds a Hamming check bit (power of two)
//   ecc_data_pos(i)     : codeword position of data bit i
// Ports: none (package).
package ram_with_ecc_pkg;

   function automatic int ecc_parity_bits(input int data_width);
      int p;
      p = 0;
      while ((1 << p) < data_width + p + 1) p++;
      return p;
   endfunction

   function automatic int ecc_code_width(input int data_width);
      return data_width + ecc_parity_bits(data_width) + 1;
   endfunction

   function automatic bit ecc_is_check_pos(input int pos);
      return (pos > 0) && ((pos & (pos - 1)) == 0);
   endfunction

   // Data bits fill the non-power-of-two positions from 1 upward, bit 0 first.
   function automatic int ecc_data_pos(input int idx);
      int pos;
      int n;
      pos = 0;
      n   = -1;
      while (n < idx) begin
         pos++;
         if (!ecc_is_check_pos(pos)) n++;
      end
      return pos;
   endfunction

endpackage

// File: rtl/ecc_secded_codec.sv
// rtl/ecc_secded_codec.sv - combinational SECDED Hamming encoder and decoder
// Purpose: encode a data word into a SECDED codeword and decode/correct a
//   stored codeword. Purely combinational; the two paths are independent.
// Ports:
//   enc_data   in  DATA_WIDTH  word to encode
//   enc_code   out CODE_WIDTH  encoded codeword
//   dec_code   in  CODE_WIDTH  codeword to decode
//   dec_data   out DATA_WIDTH  corrected data (raw data on double error)
//   dec_single out 1           correctable single-bit error seen
//   dec_double out 1           uncorrectable error seen
module ecc_secded_codec
   import ram_with_ecc_pkg::*;
#(
   parameter int DATA_WIDTH = 8
) (
   input  logic [DATA_WIDTH-1:0]                 enc_data,
   output logic [ecc_code_width(DATA_WIDTH)-1:0] enc_code,
   input  logic [ecc_code_width(DATA_WIDTH)-1:0] dec_code,
   output logic [DATA_WIDTH-1:0]                 dec_data,
   output logic                                  dec_single,
   output logic                                  dec_double
);

   localparam int P          = ecc_parity_bits(DATA_WIDTH);
   localparam int CODE_WIDTH = ecc_code_width(DATA_WIDTH);

   logic [P-1:0]          syn;
   logic                  perr;
   logic                  fix;
   logic [CODE_WIDTH-1:0] fixed;

   // Check bit 2**k accumulates every other position with bit k set; it starts
   // at zero, so XOR-ing into it in place yields the parity directly.
   always_comb begin
      enc_code = '0;
      for (int i = 0; i < DATA_WIDTH; i++)
         enc_code[ecc_data_pos(i)] = enc_data[i];
      for (int k = 0; k < P; k++)
         for (int pos = 1; pos < CODE_WIDTH; pos++)
            if (((pos >> k) & 1) == 1 && pos != (1 << k))
               enc_code[1 << k] = enc_code[1 << k] ^ enc_code[pos];
      enc_code[0] = ^enc_code[CODE_WIDTH-1:1];
   end

   always_comb begin
      syn = '0;
      for (int pos = 1; pos < CODE_WIDTH; pos++)
         if (dec_code[pos]) syn = syn ^ P'(pos);
      perr = ^dec_code;
      // Syndrome beyond the last position means several bits flipped.
      fix   = perr && (syn != '0) && (int'(syn) <= CODE_WIDTH - 1);
      fixed = dec_code;
      for (int pos = 1; pos < CODE_WIDTH; pos++)
         if (fix && int'(syn) == pos) fixed[pos] = ~dec_code[pos];
      dec_data = '0;
      for (int i = 0; i < DATA_WIDTH; i++)
         dec_data[i] = fixed[ecc_data_pos(i)];
      dec_single = perr && (int'(syn) <= CODE_WIDTH - 1);
      dec_double = ((syn != '0) && !perr) || (perr && (int'(syn) > CODE_WIDTH - 1));
   end

endmodule

// File: rtl/ram_with_ecc.sv
// rtl/ram_with_ecc.sv - single-port RAM with SECDED protection on every word
// Purpose: stores SECDED codewords; reads are decoded and registered with one
//   cycle of latency. Corrected data is never written back.
// Ports:
//   clk              in  1           rising-edge clock
//   rst              in  1           synchronous active-high reset (outputs only)
//   we               in  1           1 = write din at addr, 0 = read addr
//   addr             in  ADDR_WIDTH  word address
//   din              in  DATA_WIDTH  write data
//   dout             out DATA_WIDTH  registered read data
//   single_bit_error out 1           last read corrected a single-bit error
//   double_bit_error out 1           last read hit an uncorrectable error
// Option ECC_ERR_INJECT_EN adds:
//   inj_en           in  1           corrupt the codeword stored by this write
//   inj_mask         in  CODE_WIDTH  XOR mask applied to the stored codeword
module ram_with_ecc
   import ram_with_ecc_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  we,
   input  logic [ADDR_WIDTH-1:0] addr,
   input  logic [DATA_WIDTH-1:0] din,
   output logic [DATA_WIDTH-1:0] dout,
   output logic                  single_bit_error,
   output logic                  double_bit_error
`ifdef ECC_ERR_INJECT_EN
   ,
   input  logic                                  inj_en,
   input  logic [ecc_code_width(DATA_WIDTH)-1:0] inj_mask
`endif
);

   localparam int CODE_WIDTH = ecc_code_width(DATA_WIDTH);
   localparam int DEPTH      = 2 ** ADDR_WIDTH;

   logic [CODE_WIDTH-1:0] mem [DEPTH];
   logic [CODE_WIDTH-1:0] enc_code;
   logic [CODE_WIDTH-1:0] store_code;
   logic [CODE_WIDTH-1:0] rd_code;
   logic [DATA_WIDTH-1:0] rd_data;
   logic                  rd_single;
   logic                  rd_double;

   ecc_secded_codec #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_codec (
      .enc_data   (din),
      .enc_code   (enc_code),
      .dec_code   (rd_code),
      .dec_data   (rd_data),
      .dec_single (rd_single),
      .dec_double (rd_double)
   );

`ifdef ECC_ERR_INJECT_EN
   assign store_code = inj_en ? (enc_code ^ inj_mask) : enc_code;
`else
   assign store_code = enc_code;
`endif

   assign rd_code = mem[addr];

   // Reset blocks writes but leaves stored contents untouched.
   always_ff @(posedge clk) begin
      if (!rst && we) mem[addr] <= store_code;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         dout             <= '0;
         single_bit_error <= 1'b0;
         double_bit_error <= 1'b0;
      end else if (we) begin
         single_bit_error <= 1'b0;
         double_bit_error <= 1'b0;
      end else begin
         dout             <= rd_data;
         single_bit_error <= rd_single;
         double_bit_error <= rd_double;
      end
   end

endmodule

// File: tb/tb_ram_with_ecc.sv
// tb/tb_ram_with_ecc.sv - scoreboard bench for ram_with_ecc (ECC_ERR_INJECT_EN aware)
module tb_ram_with_ecc;
   import ram_with_ecc_pkg::*;

   localparam int DW = 8;
   localparam int AW = 4;
   localparam int CW = ecc_code_width(DW);

   typedef struct packed {
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
      logic          sbe;
      logic          dbe;
   } exp_t;

   logic          clk = 1'b0;
   logic          rst;
   logic          we;
   logic [AW-1:0] addr;
   logic [DW-1:0] din;
   logic [DW-1:0] dout;
   logic          single_bit_error;
   logic          double_bit_error;
`ifdef ECC_ERR_INJECT_EN
   logic          inj_en;
   logic [CW-1:0] inj_mask;
`endif

   exp_t          exp_q[$];
   exp_t          mon_e;
   logic [DW-1:0] model [2**AW];
   logic          rd_go;
   logic          rd_issued = 1'b0;
   int            n_cmp = 0;
   int            n_err = 0;

   ram_with_ecc #(
      .DATA_WIDTH (DW),
      .ADDR_WIDTH (AW)
   ) dut (
      .clk              (clk),
      .rst              (rst),
      .we               (we),
      .addr             (addr),
      .din              (din),
      .dout             (dout),
      .single_bit_error (single_bit_error),
      .double_bit_error (double_bit_error)
`ifdef ECC_ERR_INJECT_EN
      ,
      .inj_en           (inj_en),
      .inj_mask         (inj_mask)
`endif
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish, got running, expected finished");
      $fatal(1);
   end

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   always @(posedge clk) rd_issued <= rd_go && !rst;

   always @(negedge clk) begin
      if (rd_issued) begin
         if (exp_q.size() == 0) begin
            check_eq("rd_unexpected", 64'd1, 64'd0);
         end else begin
            mon_e = exp_q.pop_front();
            check_eq($sformatf("rd%0h_dout", mon_e.addr), 64'(dout), 64'(mon_e.data));
            check_eq($sformatf("rd%0h_sbe", mon_e.addr), 64'(single_bit_error), 64'(mon_e.sbe));
            check_eq($sformatf("rd%0h_dbe", mon_e.addr), 64'(double_bit_error), 64'(mon_e.dbe));
         end
      end
   end

   task automatic clear_inj();
`ifdef ECC_ERR_INJECT_EN
      inj_en   = 1'b0;
      inj_mask = '0;
`endif
   endtask

   task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
      @(negedge clk);
      rd_go = 1'b0;
      we    = 1'b1;
      addr  = a;
      din   = d;
      clear_inj();
      model[a] = d;
   endtask

`ifdef ECC_ERR_INJECT_EN
   task automatic do_write_inj(input logic [AW-1:0] a, input logic [DW-1:0] d,
                               input logic [CW-1:0] m);
      @(negedge clk);
      rd_go    = 1'b0;
      we       = 1'b1;
      addr     = a;
      din      = d;
      inj_en   = 1'b1;
      inj_mask = m;
      model[a] = d;
   endtask
`endif

   task automatic do_read(input logic [AW-1:0] a, input logic [DW-1:0] d,
                          input logic s, input logic db);
      exp_t e;
      @(negedge clk);
      rd_go = 1'b1;
      we    = 1'b0;
      addr  = a;
      din   = '0;
      clear_inj();
      e.addr = a;
      e.data = d;
      e.sbe  = s;
      e.dbe  = db;
      exp_q.push_back(e);
   endtask

   task automatic do_read_model(input logic [AW-1:0] a);
      do_read(a, model[a], 1'b0, 1'b0);
   endtask

   task automatic idle();
      @(negedge clk);
      rd_go = 1'b0;
      we    = 1'b0;
      addr  = '0;
      din   = '0;
      clear_inj();
   endtask

   initial begin
      logic [AW-1:0] ra;
      logic [DW-1:0] rd;

      rst   = 1'b1;
      rd_go = 1'b0;
      we    = 1'b1;
      addr  = '0;
      din   = 8'hFF;
      clear_inj();
      repeat (2) @(negedge clk);
      check_eq("rst_dout", 64'(dout), 64'h0);
      check_eq("rst_sbe", 64'(single_bit_error), 64'h0);
      check_eq("rst_dbe", 64'(double_bit_error), 64'h0);
      rst = 1'b0;

      // Write then immediate read of the same address.
      do_write(4'h3, 8'hA5);
      do_read_model(4'h3);

      // A write holds dout and clears flags.
      do_write(4'h5, 8'h3C);
      idle();
      check_eq("hold_dout", 64'(dout), 64'hA5);
      check_eq("hold_sbe", 64'(single_bit_error), 64'h0);
      check_eq("hold_dbe", 64'(double_bit_error), 64'h0);

`ifdef ECC_ERR_INJECT_EN
      // Position 3 is data bit 0, position 5 is data bit 1.
      do_write_inj(4'h3, 8'hA5, 13'h0008);
      do_read(4'h3, 8'hA5, 1'b1, 1'b0);
      do_write_inj(4'h3, 8'hA5, 13'h0001);
      do_read(4'h3, 8'hA5, 1'b1, 1'b0);
      do_write_inj(4'h3, 8'hA5, 13'h0010);
      do_read(4'h3, 8'hA5, 1'b1, 1'b0);
      do_write_inj(4'h3, 8'hA5, 13'h0028);
      do_read(4'h3, 8'hA6, 1'b0, 1'b1);
      // Flags clear on the next write; dout keeps the raw word.
      do_write(4'h4, 8'h11);
      idle();
      check_eq("inj_hold_dout", 64'(dout), 64'hA6);
      check_eq("inj_hold_dbe", 64'(double_bit_error), 64'h0);
      // Three check bits flipped: syndrome 14 lies past the last position.
      do_write_inj(4'h3, 8'hA5, 13'h0114);
      do_read(4'h3, 8'hA5, 1'b0, 1'b1);
      // Single-bit error on a data bit with different data.
      do_write_inj(4'h6, 8'h5A, 13'h1000);
      do_read(4'h6, 8'h5A, 1'b1, 1'b0);
      do_write(4'h3, 8'hA5);
`endif

      for (int i = 0; i < 16; i++) do_write(4'(i), 8'h00);
      do_write(4'hF, 8'hFF);
      for (int i = 0; i < 16; i++) do_read_model(4'(i));

      for (int i = 0; i < 6; i++) begin
         ra = 4'($urandom_range(0, 15));
         rd = 8'($urandom);
         do_write(ra, rd);
         do_read_model(ra);
      end

      // Reset beats a concurrent write and clears outputs only.
      do_write(4'h2, 8'h5A);
      do_write(4'h7, 8'hC3);
      do_read_model(4'h7);
      @(negedge clk);
      rst   = 1'b1;
      rd_go = 1'b0;
      we    = 1'b1;
      addr  = 4'h2;
      din   = 8'h99;
      @(negedge clk);
      rst = 1'b0;
      we  = 1'b0;
      check_eq("mid_rst_dout", 64'(dout), 64'h0);
      check_eq("mid_rst_sbe", 64'(single_bit_error), 64'h0);
      do_read_model(4'h2);

      idle();
      for (int i = 0; i < 10 && exp_q.size() != 0; i++) idle();
      check_eq("drain", 64'(exp_q.size()), 64'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/ram_with_ecc.md
RAM_WITH_ECC -- requirements
Module: ram_with_ecc

Interface
REQ-001 Parameter DATA_WIDTH, default 8: data word width in bits, 4..64.
REQ-002 Parameter ADDR_WIDTH, default 4: address width; depth = 2**ADDR_WIDTH words.
REQ-003 Port clk, input, 1: single clock; all logic on rising edge.
REQ-004 Port rst, input, 1: synchronous, active-high reset.
REQ-005 Port we, input, 1: 1 = write din at addr; 0 = read addr.
REQ-006 Port addr, input, ADDR_WIDTH: word address for read or write.
REQ-007 Port din, input, DATA_WIDTH: write data.
REQ-008 Port dout, output, DATA_WIDTH: registered, corrected read data.
REQ-009 Port single_bit_error, output, 1: registered; last read had a corrected single-bit error.
REQ-010 Port double_bit_error, output, 1: registered; last read had an uncorrectable double-bit error.

Function
REQ-011 SECDED Hamming code is used: P = smallest integer with 2**P >= DATA_WIDTH+P+1; CODE_WIDTH = DATA_WIDTH+P+1 (13 for DATA_WIDTH=8).
REQ-012 Codeword bit 0 holds overall parity; positions 1..DATA_WIDTH+P hold the Hamming code.
REQ-013 Check bits sit at power-of-two positions; data bits fill the remaining positions in ascending order, din[0] first.
REQ-014 Check bit 2**k = XOR of all positions with bit k set; overall parity = XOR of positions 1..DATA_WIDTH+P.
REQ-015 Write: when we=1 at a clk edge, the encoded din is stored at addr; dout holds; both flags go 0.
REQ-016 Read: when we=0 at edge N, the word at addr is decoded and dout and flags are registered at edge N (1-cycle latency, valid in cycle N+1).
REQ-017 Decode: syndrome S = XOR of positions with set bit; parity error E = XOR of all CODE_WIDTH bits.
REQ-018 S=0, E=0: clean; dout = stored data; both flags 0.
REQ-019 S!=0, E=1, S<=DATA_WIDTH+P: flip position S, output corrected data; single_bit_error=1.
REQ-020 S=0, E=1: overall-parity bit error; data is unmodified; single_bit_error=1.
REQ-021 S!=0, E=0, or E=1 with S>DATA_WIDTH+P: double_bit_error=1; single_bit_error=0; dout = raw uncorrected data bits.
REQ-022 Both flags are never 1 at the same time.
REQ-023 A write at edge N followed by a read of the same address at edge N+1 returns the new data.
REQ-024 Corrected data is not written back to memory (no scrubbing).

Reset
REQ-025 When rst=1 at an edge: dout=0, single_bit_error=0, double_bit_error=0; rst has priority over we.
REQ-026 Memory contents are not cleared by reset; reading a never-written location is undefined.

Configuration
REQ-027 When macro ECC_ERR_INJECT_EN is defined, the module adds input inj_en (1 bit) and input inj_mask (CODE_WIDTH bits); on a write with inj_en=1, the stored codeword is encoded XOR inj_mask.
REQ-028 When ECC_ERR_INJECT_EN is undefined, these ports do not exist and codewords are stored unmodified.

Structure
REQ-029 Package ram_with_ecc_pkg shall hold functions ecc_parity_bits(DATA_WIDTH) and ecc_code_width(DATA_WIDTH) and the position-mapping helpers.
REQ-030 Sub-module ecc_secded_codec shall hold the combinational encode and decode logic; ram_with_ecc holds the storage array and output registers.

Verification
REQ-031 rst=1 for 2 cycles -> dout=0x00, both flags 0.
REQ-032 Write 0xA5 to addr 0x3, then read addr 0x3 -> next cycle dout=0xA5, both flags 0.
REQ-033 Build with ECC_ERR_INJECT_EN. Write 0xA5 to addr 0x3 with a 1-bit inj_mask on a data position, then read -> dout=0xA5, single_bit_error=1, double_bit_error=0.
REQ-034 Inject a 1-bit error on bit 0 (overall parity), then read -> dout=0xA5, single_bit_error=1.
REQ-035 Inject a 2-bit error (two data positions), then read -> double_bit_error=1, single_bit_error=0, dout = raw corrupted data.
REQ-036 Write 0x00 to all 16 addresses and 0xFF to addr 0xF, then read back all addresses -> addr 0xF=0xFF, all others 0x00, no flags.
